prog_loader: RTL and testbench

Upstream boot stage for CPU_WrapperV3. It accepts a byte stream over a valid/ready handshake and writes the bytes into the wrapper's unified instruction/data memory through a dedicated write port. This replaces backdoor memory preloading. The CPU's active-low reset is held asserted while a load is in progress, then released after a fixed delay so the core starts fetching at PC 0x00.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader_rel_timer.sv | 30 +++
 rtl/prog_loader.sv | 191 +++++++++++++++++++
 tb/tb_prog_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-stage program loader.
package prog_loader_pkg;

  // CKSUM exists in the encoding in every build but is only reachable when
  // LOADER_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    RUN_WAIT = 3'd0,
    GET_ADDR = 3'd1,
    GET_LEN  = 3'd2,
    DATA     = 3'd3,
    CKSUM    = 3'd4,
    RELEASE  = 3'd5,
    RUN      = 3'd6
  } state_e;

  // A LEN byte of zero stands for a full 256-byte page.
  localparam int unsigned LEN_ZERO_N = 256;

  // Default release delay and the width of the release down-counter (1..15).
  localparam int unsigned REL_DLY_DEF = 4;
  localparam int unsigned REL_CNT_W   = 4;

endpackage

// File: rtl/prog_loader_rel_timer.sv
// Release-delay down-counter: loaded on the final memory write, done at zero.
module loader_rel_timer
  import prog_loader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [REL_CNT_W-1:0] load_val_i,
  output logic                 done_o
);

  logic [REL_CNT_W-1:0] cnt_q;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - REL_CNT_W'(1);
    end
  end

  // Terminal-count compare.
  always_comb begin
    done_o = (cnt_q == '0);
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: ADDR, LEN, data frame written into CPU memory,
// CPU reset held during the load and released REL_DLY cycles after the last
// write. Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int REL_DLY = REL_DLY_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              cpu_rstn_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CNT_W = DATA_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_rstn_q, cpu_rstn_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic              tmr_load;
  logic              tmr_done;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] sum_final;
  logic              err_q, err_d;
`endif

  // The timer starts with the final write, so it spans that write cycle.
  loader_rel_timer u_rel_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (REL_CNT_W'(REL_DLY - 1)),
    .done_o     (tmr_done)
  );

  // Ready is a function of state only; a byte is taken on valid && ready.
  always_comb begin
    ld_ready_o = (state_q == GET_ADDR) || (state_q == GET_LEN) ||
                 (state_q == DATA)     || (state_q == CKSUM);
    accept     = ld_valid_i && ld_ready_o;
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rstn_d  = cpu_rstn_q;
    busy_d      = busy_q;
    tmr_load    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
    sum_final   = sum_q + ld_data_i;
`endif
    case (state_q)
      RUN_WAIT, RUN: begin
        if (ld_start_i) begin
          state_d    = GET_ADDR;
          busy_d     = 1'b1;
          cpu_rstn_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          err_d      = 1'b0;
`endif
        end
      end
      GET_ADDR: begin
        if (accept) begin
          ptr_d   = ADDR_W'(ld_data_i);
          state_d = GET_LEN;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = ld_data_i;
`endif
        end
      end
      GET_LEN: begin
        if (accept) begin
          cnt_d   = (ld_data_i == '0) ? CNT_W'(LEN_ZERO_N) : CNT_W'(ld_data_i);
          state_d = DATA;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_final;
`endif
        end
      end
      DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = ld_data_i;
          ptr_d       = ptr_q + ADDR_W'(1);
          cnt_d       = cnt_q - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
          sum_d       = sum_final;
`endif
          if (cnt_q == CNT_W'(1)) begin
            tmr_load = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            state_d  = CKSUM;
`else
            state_d  = RELEASE;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CKSUM: begin
        if (accept) begin
          if (sum_final == '0) begin
            state_d = RELEASE;
          end else begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = RUN_WAIT;
          end
        end
      end
`endif
      RELEASE: begin
        if (tmr_done) begin
          cpu_rstn_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = RUN;
        end
      end
      default: state_d = RUN_WAIT;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN_WAIT;
      ptr_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rstn_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rstn_q  <= cpu_rstn_d;
      busy_q      <= busy_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cpu_rstn_o  = cpu_rstn_q;
  assign busy_o      = busy_q;
`ifdef LOADER_CHECKSUM_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of directed frames, hand-written reset and
// checksum sequences, and random frames against an arithmetic write model.
module tb_prog_loader;

  localparam int REL_DLY = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rstn;
  logic       busy;
  logic       err;

  prog_loader #(.ADDR_W(8), .DATA_W(8), .REL_DLY(REL_DLY)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ld_start_i  (ld_start),
    .ld_valid_i  (ld_valid),
    .ld_data_i   (ld_data),
    .ld_ready_o  (ld_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .cpu_rstn_o  (cpu_rstn),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor on the falling edge: write log, release edge timing.
  logic [15:0] wq[$];
  int cyc = 0;
  int last_we_cyc = 0;
  int rise_cyc = -1;
  logic prev_rstn = 1'b0;
  logic prev_busy = 1'b0;
  logic rise_busy_prev = 1'b0;
  logic rise_busy_now = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      last_we_cyc = cyc;
    end
    if (cpu_rstn && !prev_rstn) begin
      rise_cyc       = cyc;
      rise_busy_prev = prev_busy;
      rise_busy_now  = busy;
    end
    prev_rstn = cpu_rstn;
    prev_busy = busy;
  end

  // Session stimulus and expected writes.
  logic [7:0] s_d[256];
  int         s_g[258];
  logic [7:0] e_a[256];
  int         e_n;

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      ld_valid = 1'b0;
      ld_data  = 8'($urandom);
      @(negedge clk);
    end
    ld_valid = 1'b1;
    ld_data  = b;
    t = 0;
    while (!ld_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!ld_ready) chk("ready_timeout", {31'd0, ld_ready}, 32'd1);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  task automatic run_session(input logic [7:0] a, input logic [7:0] lenb);
    int t;
    logic [7:0] sum;
    wq.delete();
    rise_cyc = -1;
    pulse_start();
    chk("start_rstn", {31'd0, cpu_rstn}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    send_byte(a, s_g[0]);
    send_byte(lenb, s_g[1]);
    sum = a + lenb;
    for (int i = 0; i < e_n; i++) begin
      send_byte(s_d[i], s_g[2 + i]);
      sum = sum + s_d[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'(8'h00 - sum), 0);
`endif
    t = 0;
    while (!cpu_rstn && t < 40) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("release", {31'd0, cpu_rstn}, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("err_after", {31'd0, err}, 32'd0);
    chk("rel_delay", 32'(rise_cyc - last_we_cyc), 32'(REL_DLY));
    chk("busy_fall_edge", {30'd0, rise_busy_prev, rise_busy_now}, 32'b10);
    chk("wr_count", 32'(wq.size()), 32'(e_n));
    for (int i = 0; i < e_n && i < wq.size(); i++)
      chk($sformatf("wr%0d", i), {16'd0, wq[i]}, {16'd0, e_a[i], s_d[i]});
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] len;
    int         n;
    logic [7:0] d[4];
    int         g[6];
    logic [7:0] ea[4];
  } vec_t;

  vec_t vecs[4];

  initial begin
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    for (int i = 0; i < 258; i++) s_g[i] = 0;

    // Basic load, address wrap, reload from RUN, backpressure 1,0,0,1,0,1,1.
    vecs[0] = '{a:8'h00, len:8'h03, n:3, d:'{8'h88, 8'h89, 8'h24, 8'h00},
                g:'{0, 0, 0, 0, 0, 0}, ea:'{8'h00, 8'h01, 8'h02, 8'h00}};
    vecs[1] = '{a:8'hFE, len:8'h03, n:3, d:'{8'h11, 8'h22, 8'h33, 8'h00},
                g:'{0, 0, 0, 0, 0, 0}, ea:'{8'hFE, 8'hFF, 8'h00, 8'h00}};
    vecs[2] = '{a:8'h10, len:8'h01, n:1, d:'{8'h5A, 8'h00, 8'h00, 8'h00},
                g:'{0, 0, 0, 0, 0, 0}, ea:'{8'h10, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{a:8'h00, len:8'h02, n:2, d:'{8'hAA, 8'hBB, 8'h00, 8'h00},
                g:'{0, 2, 1, 0, 0, 0}, ea:'{8'h00, 8'h01, 8'h00, 8'h00}};

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_rstn", {31'd0, cpu_rstn}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      e_n = vecs[v].n;
      s_g[0] = vecs[v].g[0];
      s_g[1] = vecs[v].g[1];
      for (int i = 0; i < 4; i++) begin
        s_d[i]     = vecs[v].d[i];
        e_a[i]     = vecs[v].ea[i];
        s_g[2 + i] = vecs[v].g[2 + i];
      end
      run_session(vecs[v].a, vecs[v].len);
    end

    // Reset after two of four data bytes, with the stream still offering data.
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(8'h31, 0);
    send_byte(8'h32, 0);
    rst = 1'b1; ld_valid = 1'b1; ld_data = 8'h33;
    @(negedge clk);
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_rstn", {31'd0, cpu_rstn}, 32'd0);
    chk("mid_rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    ld_valid = 1'b0;
    chk("mid_rst_ready_idle", {31'd0, ld_ready}, 32'd0);
    chk("mid_rst_rstn_idle", {31'd0, cpu_rstn}, 32'd0);
    chk("mid_rst_wr_count", 32'(wq.size()), 32'd2);
    if (wq.size() >= 2) begin
      chk("mid_rst_wr0", {16'd0, wq[0]}, 32'h0031);
      chk("mid_rst_wr1", {16'd0, wq[1]}, 32'h0132);
    end

    // Random frames; one full 256-byte page encoded as LEN=0.
    for (int r = 0; r < 6; r++) begin
      logic [7:0] a;
      a   = 8'($urandom);
      e_n = (r == 3) ? 256 : int'($urandom_range(1, 8));
      s_g[0] = int'($urandom_range(0, 2));
      s_g[1] = int'($urandom_range(0, 2));
      for (int i = 0; i < e_n; i++) begin
        s_d[i]     = 8'($urandom);
        s_g[2 + i] = int'($urandom_range(0, 2));
        e_a[i]     = 8'((int'(a) + i) % 256);
      end
      run_session(a, (e_n == 256) ? 8'h00 : 8'(e_n));
    end

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: 00,01,88,78 sums to 0x01.
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h88, 0);
    send_byte(8'h78, 0);
    repeat (REL_DLY + 2) @(negedge clk);
    chk("cks_err", {31'd0, err}, 32'd1);
    chk("cks_busy", {31'd0, busy}, 32'd0);
    chk("cks_rstn", {31'd0, cpu_rstn}, 32'd0);
    chk("cks_wr_count", 32'(wq.size()), 32'd1);
    pulse_start();
    chk("cks_err_clear", {31'd0, err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
